// File: rtl/aic3204_pkg.sv
// Shared types and constants for the AIC3204 capture-FIFO consumer.
// Stream word layout: left sample in the low half, right sample in the high half.
package aic3204_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int FIFO_W    = 32;
  localparam int LEFT_LSB  = 0;
  localparam int RIGHT_LSB = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_CAPTURE,
    ST_OUT,
    ST_DROP_N,
    ST_DROP_P
  } rx_pair_state_t;

endpackage

// File: rtl/aic3204_rx_pair_if.sv
// FIFO read sides (left = negative wclk, right = positive wclk) plus the AXI-Stream output.
// The master modport is the pair packer's view.
interface aic3204_rx_pair_if;
  import aic3204_pkg::*;

  logic [FIFO_W-1:0] nw_fifo_rd_data;
  logic              nw_fifo_rd_valid;
  logic              nw_fifo_empty;
  logic              nw_fifo_rd_en;
  logic [FIFO_W-1:0] pw_fifo_rd_data;
  logic              pw_fifo_rd_valid;
  logic              pw_fifo_empty;
  logic              pw_fifo_rd_en;
  logic [FIFO_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;

  modport master (
    input  nw_fifo_rd_data, nw_fifo_rd_valid, nw_fifo_empty,
    output nw_fifo_rd_en,
    input  pw_fifo_rd_data, pw_fifo_rd_valid, pw_fifo_empty,
    output pw_fifo_rd_en,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    output nw_fifo_rd_data, nw_fifo_rd_valid, nw_fifo_empty,
    input  nw_fifo_rd_en,
    output pw_fifo_rd_data, pw_fifo_rd_valid, pw_fifo_empty,
    input  pw_fifo_rd_en,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );

endinterface

// File: rtl/rx_skew_timer.sv
// Counts consecutive cycles of left/right imbalance; expire flags the last allowed cycle.
module rx_skew_timer #(
  parameter int SKEW_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(SKEW_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(SKEW_TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (active && (cnt != CNT_LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = active && (cnt == CNT_LAST);

endmodule

// File: rtl/aic3204_rx_pair.sv
// Pops left/right capture FIFOs in lockstep, packs {right, left} onto an AXI-Stream
// master framed by tlast, and discards orphaned samples after a skew timeout.
module aic3204_rx_pair
  import aic3204_pkg::*;
#(
  parameter int FRAME_LEN    = 256,
  parameter int SKEW_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clr_counts,
  aic3204_rx_pair_if.master   bus,
  output logic [31:0]         pair_count,
  output logic [15:0]         skew_drop_count
);

  localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_LEN - 1);

  rx_pair_state_t state, state_nxt;

  logic                skew_active, skew_expire;
  logic                left_vld_p0, right_vld_p0;
  logic [SAMPLE_W-1:0] left_p0, right_p0;
  logic [SAMPLE_W-1:0] left_cur, right_cur;
  logic                both_rdy, load, hs, drop_done, drop_issued;
  logic                nw_rd_en_c, pw_rd_en_c;
  logic [FC_W-1:0]     frame_cnt;
  logic [FIFO_W-1:0]   tdata_q;
  logic                tlast_q;
  logic                unused_hi_bits;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Only the low halves of the FIFO words carry samples.
  assign unused_hi_bits = ^{bus.nw_fifo_rd_data[FIFO_W-1:SAMPLE_W],
                            bus.pw_fifo_rd_data[FIFO_W-1:SAMPLE_W]};

  assign left_cur  = bus.nw_fifo_rd_valid ? bus.nw_fifo_rd_data[LEFT_LSB +: SAMPLE_W] : left_p0;
  assign right_cur = bus.pw_fifo_rd_valid ? bus.pw_fifo_rd_data[LEFT_LSB +: SAMPLE_W] : right_p0;
  assign both_rdy  = (left_vld_p0 | bus.nw_fifo_rd_valid) & (right_vld_p0 | bus.pw_fifo_rd_valid);

  assign skew_active = (state == ST_IDLE) && enable && (bus.nw_fifo_empty ^ bus.pw_fifo_empty);

  rx_skew_timer #(.SKEW_TIMEOUT(SKEW_TIMEOUT)) u_skew_timer (
    .clk    (clk),
    .reset  (reset),
    .active (skew_active),
    .clear  (!skew_active),
    .expire (skew_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (enable && !bus.nw_fifo_empty && !bus.pw_fifo_empty) state_nxt = ST_POP;
        else if (skew_expire) state_nxt = bus.nw_fifo_empty ? ST_DROP_P : ST_DROP_N;
      end
      ST_POP:     state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (both_rdy) state_nxt = ST_OUT;
      ST_OUT: begin
        if (bus.m_axis_tready) begin
          state_nxt = (enable && !bus.nw_fifo_empty && !bus.pw_fifo_empty) ? ST_POP : ST_IDLE;
        end
      end
      ST_DROP_N: if (drop_issued && bus.nw_fifo_rd_valid) state_nxt = ST_IDLE;
      ST_DROP_P: if (drop_issued && bus.pw_fifo_rd_valid) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    nw_rd_en_c = 1'b0;
    pw_rd_en_c = 1'b0;
    load       = 1'b0;
    hs         = 1'b0;
    drop_done  = 1'b0;
    unique case (state)
      ST_POP: begin
        nw_rd_en_c = !bus.nw_fifo_empty;
        pw_rd_en_c = !bus.pw_fifo_empty;
      end
      ST_CAPTURE: load = both_rdy;
      ST_OUT:     hs   = bus.m_axis_tready;
      ST_DROP_N: begin
        nw_rd_en_c = !drop_issued && !bus.nw_fifo_empty;
        drop_done  = drop_issued && bus.nw_fifo_rd_valid;
      end
      ST_DROP_P: begin
        pw_rd_en_c = !drop_issued && !bus.pw_fifo_empty;
        drop_done  = drop_issued && bus.pw_fifo_rd_valid;
      end
      default: ;
    endcase
  end

  assign bus.nw_fifo_rd_en  = nw_rd_en_c;
  assign bus.pw_fifo_rd_en  = pw_rd_en_c;
  assign bus.m_axis_tvalid  = (state == ST_OUT);
  assign bus.m_axis_tdata   = tdata_q;
  assign bus.m_axis_tlast   = tlast_q;

  // Stage p0: per-side capture; each side may land on a different cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      left_p0      <= '0;
      right_p0     <= '0;
      left_vld_p0  <= 1'b0;
      right_vld_p0 <= 1'b0;
      tdata_q      <= '0;
      tlast_q      <= 1'b0;
      frame_cnt    <= '0;
      drop_issued  <= 1'b0;
    end else begin
      if (state == ST_CAPTURE) begin
        if (bus.nw_fifo_rd_valid) begin
          left_p0     <= left_cur;
          left_vld_p0 <= 1'b1;
        end
        if (bus.pw_fifo_rd_valid) begin
          right_p0     <= right_cur;
          right_vld_p0 <= 1'b1;
        end
        if (load) begin
          left_vld_p0                        <= 1'b0;
          right_vld_p0                       <= 1'b0;
          tdata_q[LEFT_LSB +: SAMPLE_W]      <= left_cur;
          tdata_q[RIGHT_LSB +: SAMPLE_W]     <= right_cur;
          tlast_q                            <= (frame_cnt == FC_LAST);
        end
      end
      if (hs) frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + 1'b1;
      drop_issued <= ((state == ST_DROP_N) || (state == ST_DROP_P)) &&
                     (drop_issued || nw_rd_en_c || pw_rd_en_c);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr_counts) begin
      pair_count      <= '0;
      skew_drop_count <= '0;
    end else begin
      if (hs)        pair_count      <= pair_count + 32'd1;
      if (drop_done) skew_drop_count <= sat_inc16(skew_drop_count);
    end
  end

endmodule

// File: tb/tb_aic3204_rx_pair.sv
// Scoreboard bench: queue-based FIFO models feed the packer; expected stereo words
// are queued at push time and a negedge monitor compares every stream handshake.
module tb_aic3204_rx_pair;
  import aic3204_pkg::*;

  localparam int FRAME_LEN    = 4;
  localparam int SKEW_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        clr_counts;
  logic [31:0] pair_count;
  logic [15:0] skew_drop_count;

  aic3204_rx_pair_if bus();

  aic3204_rx_pair #(.FRAME_LEN(FRAME_LEN), .SKEW_TIMEOUT(SKEW_TIMEOUT)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .clr_counts      (clr_counts),
    .bus             (bus),
    .pair_count      (pair_count),
    .skew_drop_count (skew_drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  logic [15:0] nwq[$];
  logic [15:0] pwq[$];
  logic [31:0] expq[$];
  int exp_pairs = 0;
  int exp_drops = 0;
  int n_tlast   = 0;
  int out_idx   = 0;
  int tready_mode = 1;

  // FIFO models: data one cycle after rd_en, garbage upper bits and idle data.
  always @(posedge clk) begin
    bus.nw_fifo_rd_valid <= 1'b0;
    bus.nw_fifo_rd_data  <= $urandom;
    if (bus.nw_fifo_rd_en) begin
      chk("nw_pop_nonempty", 32'(nwq.size() != 0), 32'd1);
      if (nwq.size() != 0) begin
        bus.nw_fifo_rd_data  <= {16'($urandom), nwq.pop_front()};
        bus.nw_fifo_rd_valid <= 1'b1;
      end
    end
    bus.nw_fifo_empty <= (nwq.size() == 0);
  end

  always @(posedge clk) begin
    bus.pw_fifo_rd_valid <= 1'b0;
    bus.pw_fifo_rd_data  <= $urandom;
    if (bus.pw_fifo_rd_en) begin
      chk("pw_pop_nonempty", 32'(pwq.size() != 0), 32'd1);
      if (pwq.size() != 0) begin
        bus.pw_fifo_rd_data  <= {16'($urandom), pwq.pop_front()};
        bus.pw_fifo_rd_valid <= 1'b1;
      end
    end
    bus.pw_fifo_empty <= (pwq.size() == 0);
  end

  always @(posedge clk) begin
    #2;
    case (tready_mode)
      0:       bus.m_axis_tready = 1'b0;
      1:       bus.m_axis_tready = 1'b1;
      default: bus.m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  end

  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (reset) begin
      expq.delete();
      exp_pairs = 0;
      out_idx   = 0;
      n_tlast   = 0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
        chk("hold_tdata", bus.m_axis_tdata, prev_data);
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (expq.size() == 0) begin
          chk("unexpected_output_queue_depth", 32'(expq.size()), 32'd1);
        end else begin
          chk("tdata", bus.m_axis_tdata, expq.pop_front());
          chk("tlast", 32'(bus.m_axis_tlast), 32'((out_idx % FRAME_LEN) == FRAME_LEN - 1));
          out_idx++;
          if (bus.m_axis_tlast) n_tlast++;
        end
        if (clr_counts) exp_pairs = 0;
        else            exp_pairs++;
      end else if (clr_counts) begin
        exp_pairs = 0;
      end
      prev_hold = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev_data = bus.m_axis_tdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    nwq.push_back(l);
    pwq.push_back(r);
    expq.push_back({r, l});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i = 0;
    while ((expq.size() != 0 || bus.m_axis_tvalid) && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(name, 32'(expq.size()), 32'd0);
  endtask

  task automatic wait_tvalid(input string name, input int budget);
    int i = 0;
    while (!bus.m_axis_tvalid && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(name, 32'(bus.m_axis_tvalid), 32'd1);
  endtask

  initial begin
    int t_fall, t_valid, nw_rd, pw_rd, wait_cnt;
    reset = 1'b1; enable = 1'b0; clr_counts = 1'b0; tready_mode = 1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    chk("rst_tdata", bus.m_axis_tdata, 32'd0);
    chk("rst_tlast", 32'(bus.m_axis_tlast), 32'd0);
    chk("rst_rd_en", 32'({bus.nw_fifo_rd_en, bus.pw_fifo_rd_en}), 32'd0);
    chk("rst_pair_count", pair_count, 32'd0);
    chk("rst_skew_count", 32'(skew_drop_count), 32'd0);
    tick();
    reset = 1'b0; enable = 1'b1;

    // Single pair: latency from both-non-empty to tvalid, one-cycle pops.
    push_pair(16'h1234, 16'hABCD);
    t_fall = -1; t_valid = -1; nw_rd = 0; pw_rd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.nw_fifo_rd_en) nw_rd++;
      if (bus.pw_fifo_rd_en) pw_rd++;
      if (!bus.nw_fifo_empty && !bus.pw_fifo_empty && t_fall < 0) t_fall = i;
      if (bus.m_axis_tvalid && t_valid < 0) t_valid = i;
    end
    chk("t1_latency", 32'(t_valid - t_fall), 32'd3);
    chk("t1_nw_rd_pulses", 32'(nw_rd), 32'd1);
    chk("t1_pw_rd_pulses", 32'(pw_rd), 32'd1);
    chk("t1_pair_count", pair_count, 32'd1);

    // Framing: 9 pairs from a fresh frame counter.
    tick(); reset = 1'b1; tick(); reset = 1'b0; exp_drops = 0;
    for (int i = 0; i < 9; i++) push_pair(16'($urandom), 16'($urandom));
    wait_drain("t2_drain", 200);
    tick();
    chk("t2_pair_count", pair_count, 32'd9);
    chk("t2_tlast_count", 32'(n_tlast), 32'd2);

    // Backpressure: three queued pairs held behind tready low.
    tready_mode = 0;
    for (int i = 0; i < 3; i++) push_pair(16'($urandom), 16'($urandom));
    nw_rd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.nw_fifo_rd_en) nw_rd++;
    end
    chk("t3_pops_while_held", 32'(nw_rd), 32'd1);
    chk("t3_tvalid_held", 32'(bus.m_axis_tvalid), 32'd1);
    tick(); tready_mode = 1;
    wait_drain("t3_drain", 200);

    // Skew: a lone left word is discarded after the timeout.
    tick();
    nwq.push_back(16'h5A5A);
    wait_cnt = 0; nw_rd = 0; pw_rd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.nw_fifo_rd_en) nw_rd++;
      if (bus.pw_fifo_rd_en) pw_rd++;
      if (!bus.nw_fifo_empty && nw_rd == 0) wait_cnt++;
    end
    exp_drops = 1;
    chk("t4_timeout_cycles", 32'(wait_cnt), 32'(SKEW_TIMEOUT));
    chk("t4_nw_drop_pulses", 32'(nw_rd), 32'd1);
    chk("t4_pw_pulses", 32'(pw_rd), 32'd0);
    chk("t4_skew_count", 32'(skew_drop_count), 32'd1);
    tick();
    push_pair(16'h0F0F, 16'hF0F0);
    wait_drain("t4_drain", 100);

    // Enable gating, and enable falling while a pair is presented.
    tick(); enable = 1'b0;
    push_pair(16'h1111, 16'h2222);
    push_pair(16'h3333, 16'h4444);
    nw_rd = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.nw_fifo_rd_en || bus.pw_fifo_rd_en) nw_rd++;
    end
    chk("t5_no_pop_disabled", 32'(nw_rd), 32'd0);
    tick(); tready_mode = 0; enable = 1'b1;
    wait_tvalid("t5_tvalid", 20);
    tick(); enable = 1'b0; tready_mode = 1;
    nw_rd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.nw_fifo_rd_en || bus.pw_fifo_rd_en) nw_rd++;
    end
    chk("t5_no_pop_after_fall", 32'(nw_rd), 32'd0);
    chk("t5_left_remaining", 32'(nwq.size()), 32'd1);
    tick(); enable = 1'b1;
    wait_drain("t5_drain", 100);

    // Reset while capturing loses the popped pair.
    tick();
    push_pair(16'hDEAD, 16'hBEEF);
    begin
      int i = 0;
      while (!bus.nw_fifo_rd_en && i < 20) begin
        @(negedge clk);
        i++;
      end
    end
    chk("t6_pop_seen", 32'(bus.nw_fifo_rd_en), 32'd1);
    tick(); reset = 1'b1;
    tick(); reset = 1'b0; exp_drops = 0;
    @(negedge clk);
    chk("t6_tvalid_after_reset", 32'(bus.m_axis_tvalid), 32'd0);
    chk("t6_pair_count_reset", pair_count, 32'd0);
    chk("t6_skew_count_reset", 32'(skew_drop_count), 32'd0);
    repeat (10) tick();

    // Counter clear coincident with a handshake.
    tready_mode = 0;
    push_pair(16'h7777, 16'h8888);
    wait_tvalid("t6_clr_tvalid", 20);
    tick(); clr_counts = 1'b1; tready_mode = 1;
    tick(); clr_counts = 1'b0;
    @(negedge clk);
    chk("t6_clr_wins", pair_count, 32'd0);
    exp_drops = 0;

    // Random traffic with random backpressure.
    tick(); tready_mode = 2;
    for (int i = 0; i < 30; i++) begin
      push_pair(16'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 4)) tick();
    end
    wait_drain("rand_drain", 2000);
    tick(); tick();
    chk("final_pair_count", pair_count, 32'(exp_pairs));
    chk("final_skew_count", 32'(skew_drop_count), 32'(exp_drops));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
